// File: rtl/obstacle_spawner_pkg.sv
// Shared constants and types for the obstacle spawner: game-state codes,
// screen width, FSM states and the LFSR feedback taps.
package obstacle_spawner_pkg;

  localparam logic [1:0] GS_IDLE  = 2'b00;
  localparam logic [1:0] GS_RUN   = 2'b10;
  localparam logic [1:0] GS_PAUSE = 2'b01;

  localparam int SCREEN_W = 640;

  // Fibonacci taps 16,14,13,11 expressed as a bit mask over state[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_CLEAR = 2'd1,
    ST_GAP        = 2'd2,
    ST_ARMED      = 2'd3
  } spawn_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Bus between the game logic / obstacle mover (master) and the spawner (slave).
interface obstacle_spawner_if;
  logic        moveClk;
  logic [1:0]  gameState;
  logic [10:0] obsX;
  logic [7:0]  obsW;
  logic        release_req;
  logic [3:0]  obsSel;
  logic        gapActive;

  modport master (
    output moveClk, gameState, obsX, obsW,
    input  release_req, obsSel, gapActive
  );

  modport slave (
    input  moveClk, gameState, obsX, obsW,
    output release_req, obsSel, gapActive
  );
endinterface

// File: rtl/spawn_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per enable; loads SEED in reset.
module spawn_lfsr
  import obstacle_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEED;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: paces obstacle releases with a min+random gap in move ticks.
// Optional macro SPAWN_RANDOM_SEL_EN latches a random sprite select at each arming.
//
// state       | meaning
// ST_IDLE     | game not running, no request
// ST_GAP      | counting down the gap before the next release
// ST_ARMED    | release held until the new obstacle appears on screen
// ST_WAIT_CLEAR | obstacle on screen, waiting for it to leave
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int          MIN_GAP   = 120,
  parameter int          RAND_BITS = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk,
  input logic rst,
  obstacle_spawner_if.slave bus
);

  localparam int GAP_MAX = MIN_GAP + (2 ** RAND_BITS) - 1;
  localparam int CNT_W   = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

  logic             mv_meta, mv_sync, mv_prev;
  logic             tick;
  logic             on_screen;
  logic [11:0]      obs_right;
  logic [15:0]      lfsr_state;
  logic             unused_lfsr;
  logic [CNT_W-1:0] gap_cnt, gap_nxt, gap_load;
  spawn_state_t     state, state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv_meta <= 1'b0;
      mv_sync <= 1'b0;
      mv_prev <= 1'b0;
    end else begin
      mv_meta <= bus.moveClk;
      mv_sync <= mv_meta;
      mv_prev <= mv_sync;
    end
  end

  assign tick = mv_sync & ~mv_prev;

  // Obstacles partly off the left edge have wrapped X; the right edge tells us.
  assign obs_right = {1'b0, bus.obsX} + {4'b0000, bus.obsW};
  assign on_screen = ({1'b0, bus.obsX} < 12'(SCREEN_W)) ||
                     (bus.obsX[10] && (obs_right >= 12'd2048));

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (tick),
    .state  (lfsr_state)
  );

  assign unused_lfsr = ^lfsr_state;
  assign gap_load    = CNT_W'(MIN_GAP) + CNT_W'(lfsr_state[RAND_BITS-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (bus.gameState)
      GS_IDLE: begin
        state_nxt = ST_IDLE;
        gap_nxt   = '0;
      end
      GS_RUN: begin
        case (state)
          ST_IDLE: begin
            state_nxt = ST_GAP;
            gap_nxt   = gap_load;
          end
          ST_GAP: begin
            // The tick that brings the count to zero arms, so a load of N spans N ticks.
            if (tick) begin
              if (gap_cnt <= CNT_W'(1)) begin
                state_nxt = ST_ARMED;
                gap_nxt   = '0;
              end else begin
                gap_nxt = gap_cnt - CNT_W'(1);
              end
            end
          end
          ST_ARMED: begin
            if (tick && on_screen) state_nxt = ST_WAIT_CLEAR;
          end
          ST_WAIT_CLEAR: begin
            if (tick && !on_screen) begin
              state_nxt = ST_GAP;
              gap_nxt   = gap_load;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.release_req = (state == ST_ARMED);
  assign bus.gapActive   = (state == ST_GAP);

`ifdef SPAWN_RANDOM_SEL_EN
  logic [3:0] sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= 4'b0000;
    end else if ((state_nxt == ST_ARMED) && (state != ST_ARMED)) begin
      sel_q <= {2'b00, lfsr_state[1:0]};
    end
  end

  assign bus.obsSel = sel_q;
`else
  assign bus.obsSel = 4'b0000;
`endif

endmodule

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 Parameter MIN_GAP, default 120: minimum move ticks between an obstacle leaving the screen and the next release.
REQ-002 Parameter RAND_BITS, default 7: width of the random extra gap; extra gap ranges 0..2^RAND_BITS-1 ticks.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR value loaded at reset; SHALL be nonzero.
REQ-004 Port clk, input, 1: system clock; single clock domain.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port moveClk, input, 1: obstacle movement clock, treated as a data signal and sampled on clk.
REQ-007 Port gameState, input, 2: 00 idle, 10 running, 01 paused; 11 SHALL be treated as paused.
REQ-008 Port obsX, input, 11: current obstacle left edge from the obstacle mover (unsigned; underflow wraps).
REQ-009 Port obsW, input, 8: current obstacle width.
REQ-010 Port release, output, 1: level request to the mover to start a new obstacle.
REQ-011 Port obsSel, output, 4: obstacle sprite select for the next obstacle.
REQ-012 Port gapActive, output, 1: high while the gap counter is counting (debug/score use).

Function
REQ-013 moveClk SHALL pass through a 2-flop synchronizer; tick = one-clk pulse on each synchronized rising edge.
REQ-014 onScreen = (obsX < 640) OR (obsX[10]=1 AND obsX+obsW, computed 12-bit, >= 2048); all sums widened before compare.
REQ-015 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL advance on every tick, in every state.
REQ-016 FSM states IDLE, WAIT_CLEAR, GAP, ARMED.
REQ-017 IDLE: release=0; on gameState=10 go to GAP, loading gapCnt = MIN_GAP + LFSR[RAND_BITS-1:0].
REQ-018 GAP: gapCnt decrements by 1 per tick; at gapCnt=0 on a tick go to ARMED.
REQ-019 ARMED: release=1; it SHALL be held until a tick with onScreen=1, which moves the FSM to WAIT_CLEAR with release=0 in the next clk.
REQ-020 WAIT_CLEAR: on the first tick with onScreen=0, go to GAP, reloading gapCnt as in REQ-017.
REQ-021 gameState paused (01/11): FSM state, gapCnt and release SHALL hold; the LFSR still advances.
REQ-022 gameState=00 in any state: go to IDLE on the next clk, release=0, gapCnt=0.
REQ-023 A tick coinciding with a gameState change SHALL be evaluated under the new gameState.
REQ-024 gapActive = 1 exactly when the FSM is in GAP.
REQ-025 gapCnt width SHALL hold MIN_GAP + 2^RAND_BITS - 1 without overflow.

Reset
REQ-026 While rst=0: FSM=IDLE, release=0, obsSel=0, gapActive=0, gapCnt=0, LFSR=LFSR_SEED, synchronizer and edge-detect flops=0.
REQ-027 Reset deassertion mid-game SHALL restart from IDLE; no release pulse is emitted because of the reset itself.

Configuration
REQ-028 Macro SPAWN_RANDOM_SEL_EN defined: on entry to ARMED, obsSel latches {2'b00, LFSR[1:0]} and holds until the next ARMED entry.
REQ-029 SPAWN_RANDOM_SEL_EN undefined: obsSel SHALL be constant 4'b0000.

Structure
REQ-030 A shared package SHALL hold the gameState encodings (IDLE/RUN/PAUSE), SCREEN_W=640, the FSM state enumeration and the LFSR tap constant.
REQ-031 The LFSR SHALL be a sub-module, spawn_lfsr (enable, seed parameter, 16-bit state out).

Verification
REQ-032 Reset with gameState=00 and 50 ticks -> release=0, obsSel=0, gapActive=0 throughout.
REQ-033 MIN_GAP=4, RAND_BITS=1, gameState 00->10 -> gapActive high 4..5 ticks, then release=1 held until obsX<640 is driven; release falls 1 clk after that tick.
REQ-034 During GAP, gameState=01 for 30 ticks, then 10 -> gapCnt unchanged across the pause; release is delayed by exactly 30 ticks.
REQ-035 In WAIT_CLEAR with obsX=2046, obsW=20 -> stays in WAIT_CLEAR (onScreen); obsX=700 -> GAP entered on the next tick.
REQ-036 rst pulsed low while in ARMED -> release=0 asynchronously, FSM=IDLE, LFSR=16'hACE1.
REQ-037 SPAWN_RANDOM_SEL_EN defined, 20 spawns -> obsSel always in 0..3, changes only at ARMED entry; undefined -> obsSel=0 always.
